// File: rtl/result_bram_ctrl.sv
// result_bram_ctrl
//   Job sequencer and sole master of the dual-port result BRAM. Each job
//   clears its bit range, accepts scattered single-bit result writes, then
//   drains the range as a WORD_W-bit stream under valid/ready backpressure.
//
// Ports
//   clk, reset                 : clock, synchronous active-high reset
//   start, num_bits            : job start pulse and size (sampled in IDLE)
//   busy, done                 : job status, one-cycle completion pulse
//   in_valid/in_ready/in_idx/in_bit/in_last : result-bit write stream
//   drop_cnt                   : saturating count of out-of-range writes
//   out_valid/out_ready/out_data/out_last   : drained word stream
//   bram_wea/web, bram_addra/addrb, bram_dina/dinb : BRAM port controls
//   bram_doutb                 : BRAM port B read data
module result_bram_ctrl #(
  parameter int ADDR_W = 20,
  parameter int WORD_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_bits,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_idx,
  input  logic              in_bit,
  input  logic              in_last,
  output logic [15:0]       drop_cnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              bram_wea,
  output logic              bram_web,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [ADDR_W-1:0] bram_addrb,
  output logic              bram_dina,
  output logic              bram_dinb,
  input  logic [WORD_W-1:0] bram_doutb
);

  localparam int LOG_W  = $clog2(WORD_W);
  localparam int WCNT_W = ADDR_W - LOG_W + 1;   // holds word counts up to 2**(ADDR_W-LOG_W)
  localparam int DEPTH  = RD_LAT + 1;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_COLLECT, S_TURN, S_DRAIN, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   num_bits_q, num_bits_d;
  logic [WCNT_W-1:0]   words_q, words_d;
  logic [ADDR_W:0]     clear_c_q, clear_c_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;
  logic [WCNT_W-1:0]   rd_word_q, rd_word_d;
  logic [WCNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [RD_LAT-1:0]   pipe_q, pipe_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic [WORD_W-1:0]   fifo_mem_q [DEPTH];

  logic [ADDR_W:0]     nb_round;
  logic [WCNT_W-1:0]   words_start;
  logic [ADDR_W:0]     clear_end;
  logic                clear_last;
  logic                in_range;
  logic                last_word;
  logic                out_pop;
  logic                rd_issue;
  logic                fifo_push;
  logic [CNT_W-1:0]    inflight;
  logic [CNT_W-1:0]    credit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign nb_round    = {1'b0, num_bits} + (ADDR_W + 1)'(WORD_W - 1);
  assign words_start = nb_round[ADDR_W:LOG_W];
  assign clear_end   = {words_q, {LOG_W{1'b0}}};
  // Two bits are cleared per cycle; WORD_W is even so the end is hit exactly.
  assign clear_last  = (clear_c_q + (ADDR_W + 1)'(2)) == clear_end;
  assign in_range    = in_idx < num_bits_q;
  assign last_word   = out_cnt_q == (words_q - WCNT_W'(1));
  assign out_pop     = out_valid && out_ready;

  // State register and all sequential state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      num_bits_q <= '0;
      words_q    <= '0;
      clear_c_q  <= '0;
      drop_cnt_q <= '0;
      rd_word_q  <= '0;
      out_cnt_q  <= '0;
      pipe_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      num_bits_q <= num_bits_d;
      words_q    <= words_d;
      clear_c_q  <= clear_c_d;
      drop_cnt_q <= drop_cnt_d;
      rd_word_q  <= rd_word_d;
      out_cnt_q  <= out_cnt_d;
      pipe_q     <= pipe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Read-data FIFO storage; contents are only meaningful under fifo_cnt_q.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem_q[wr_ptr_q] <= bram_doutb;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = (num_bits == '0) ? S_DONE : S_CLEAR;
      S_CLEAR:   if (clear_last) state_d = S_COLLECT;
      S_COLLECT: if (in_valid && in_last) state_d = S_TURN;
      S_TURN:    state_d = S_DRAIN;
      S_DRAIN:   if (out_pop && last_word) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Job counters.
  always_comb begin
    num_bits_d = num_bits_q;
    words_d    = words_q;
    clear_c_d  = clear_c_q;
    drop_cnt_d = drop_cnt_q;
    rd_word_d  = rd_word_q;
    out_cnt_d  = out_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_bits_d = num_bits;
          words_d    = words_start;
          clear_c_d  = '0;
          drop_cnt_d = '0;
        end
      end
      S_CLEAR: clear_c_d = clear_c_q + (ADDR_W + 1)'(2);
      S_COLLECT: begin
        if (in_valid && !in_range && (drop_cnt_q != 16'hFFFF)) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
        end
      end
      S_TURN: begin
        rd_word_d = '0;
        out_cnt_d = '0;
      end
      S_DRAIN: begin
        if (rd_issue) rd_word_d = rd_word_q + WCNT_W'(1);
        if (out_pop)  out_cnt_d = out_cnt_q + WCNT_W'(1);
      end
      default: ;
    endcase
  end

  // Read pipeline and FIFO bookkeeping. The word being popped this cycle
  // frees its slot, so it is credited back before deciding on a new read;
  // this keeps one read per cycle with out_ready high while never
  // committing more reads than the FIFO can absorb.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CNT_W'(pipe_q[i]);
    end
    credit   = fifo_cnt_q - CNT_W'(out_pop) + inflight;
    rd_issue = (state_q == S_DRAIN) && (rd_word_q < words_q) &&
               (credit <= CNT_W'(RD_LAT));
    pipe_d    = '0;
    pipe_d[0] = rd_issue;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    fifo_push  = pipe_q[RD_LAT-1];
    wr_ptr_d   = fifo_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = out_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CNT_W'(fifo_push) - CNT_W'(out_pop);
  end

  // Outputs.
  always_comb begin
    busy       = state_q != S_IDLE;
    done       = state_q == S_DONE;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    bram_wea   = 1'b0;
    bram_web   = 1'b0;
    bram_addra = '0;
    bram_addrb = '0;
    bram_dina  = 1'b0;
    bram_dinb  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        bram_wea   = 1'b1;
        bram_web   = 1'b1;
        bram_addra = clear_c_q[ADDR_W-1:0];
        bram_addrb = clear_c_q[ADDR_W-1:0] + ADDR_W'(1);
      end
      S_COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && in_range) begin
          bram_wea   = 1'b1;
          bram_addra = in_idx;
          bram_dina  = in_bit;
        end
      end
      S_DRAIN: begin
        bram_addrb = {rd_word_q[WCNT_W-2:0], {LOG_W{1'b0}}};
        out_valid  = fifo_cnt_q != '0;
        if (out_valid) begin
          out_data = fifo_mem_q[rd_ptr_q];
          out_last = last_word;
        end
      end
      default: ;
    endcase
  end

  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_result_bram_ctrl.sv
module tb_result_bram_ctrl;
  localparam int AW = 20;
  localparam int WW = 32;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] num_bits;
  logic          busy, done;
  logic          in_valid, in_ready, in_bit, in_last;
  logic [AW-1:0] in_idx;
  logic [15:0]   drop_cnt;
  logic          out_valid, out_ready, out_last;
  logic [WW-1:0] out_data;
  logic          bram_wea, bram_web, bram_dina, bram_dinb;
  logic [AW-1:0] bram_addra, bram_addrb;
  logic [WW-1:0] bram_doutb;

  result_bram_ctrl #(.ADDR_W(AW), .WORD_W(WW), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .num_bits(num_bits),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_idx(in_idx), .in_bit(in_bit), .in_last(in_last), .drop_cnt(drop_cnt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .bram_wea(bram_wea), .bram_web(bram_web),
    .bram_addra(bram_addra), .bram_addrb(bram_addrb), .bram_dina(bram_dina),
    .bram_dinb(bram_dinb), .bram_doutb(bram_doutb)
  );

  always #5 clk = ~clk;

  // BRAM model: bit-write ports, word-read port B with one cycle latency.
  bit mem [0:(1<<AW)-1];

  function automatic logic [WW-1:0] rd_word(input logic [AW-1:0] a);
    logic [WW-1:0] w;
    for (int k = 0; k < WW; k++) w[k] = mem[a + AW'(k)];
    return w;
  endfunction

  always @(posedge clk) begin
    bram_doutb <= rd_word(bram_addrb);
    if (bram_wea) mem[bram_addra] <= bram_dina;
    if (bram_web) mem[bram_addrb] <= bram_dinb;
  end

  // Activity counters, read as before/after differences.
  int clr_cnt = 0, en_cnt = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (bram_wea && bram_web) clr_cnt++;
    if (bram_wea || bram_web) en_cnt++;
    if (done) done_cnt++;
  end

  int checks = 0, failures = 0;
  int wq_idx[$];
  bit wq_bit[$];
  logic [31:0] got[$];
  logic [31:0] exp_q[$];
  int exp_drop;

  typedef struct packed {
    logic [19:0]      nb;
    logic [2:0]       nw;
    logic [3:0][19:0] idx;
    logic [3:0]       val;
    logic [3:0]       nexp;
    logic [7:0][31:0] exp;
    logic [15:0]      drop;
    logic [6:0]       rdy;
    logic [8:0]       clr;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: job result computed directly from the write list.
  task automatic model(input int nb);
    bit b[];
    int nw;
    nw = (nb + 31) / 32;
    b = new[nw * 32];
    exp_q.delete();
    exp_drop = 0;
    foreach (wq_idx[i]) begin
      if (wq_idx[i] < nb) b[wq_idx[i]] = wq_bit[i];
      else if (exp_drop < 65535) exp_drop++;
    end
    for (int w = 0; w < nw; w++) begin
      logic [31:0] v;
      for (int k = 0; k < 32; k++) v[k] = b[w*32 + k];
      exp_q.push_back(v);
    end
  endtask

  task automatic cmp_words(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      chk($sformatf("%s_word%0d", tag, k), got[k], exp_q[k]);
    end
  endtask

  task automatic run_job(input int nb, input int rdy_pct, input int abort_after, input bit gaps);
    int i, cyc, nw;
    bit stall, finished;
    logic [31:0] hold;
    got.delete();
    nw = (nb + 31) / 32;
    @(negedge clk);
    start = 1'b1;
    num_bits = AW'(nb);
    @(negedge clk);
    start = 1'b0;
    i = 0;
    cyc = 0;
    while (i < wq_idx.size() && cyc < 20000) begin
      if (in_ready && (!gaps || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_idx   = AW'(wq_idx[i]);
        in_bit   = wq_bit[i];
        in_last  = (i == wq_idx.size() - 1);
        #1;
        chk("wr_en", bram_wea, wq_idx[i] < nb);
        if (wq_idx[i] < nb) chk("wr_addr", bram_addra, wq_idx[i]);
        i++;
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (cyc >= 20000) begin
      failures++;
      $display("FAIL collect_timeout actual=%0d writes required=%0d", i, wq_idx.size());
    end
    stall = 1'b0;
    finished = 1'b0;
    hold = '0;
    cyc = 0;
    while (cyc < 5000 && !finished) begin
      if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, hold);
      end
      if (rdy_pct == 100 && got.size() > 0 && got.size() < nw) chk("no_bubble", out_valid, 1);
      out_ready = ($urandom_range(1, 100) <= rdy_pct);
      stall = out_valid && !out_ready;
      hold  = out_data;
      if (out_valid && out_ready) begin
        chk("out_last", out_last, got.size() == nw - 1);
        got.push_back(out_data);
        if (got.size() >= nw) finished = 1'b1;
        if (abort_after > 0 && got.size() == abort_after) begin
          reset = 1'b1;
          out_ready = 1'b0;
          @(negedge clk);
          @(negedge clk);
          reset = 1'b0;
          return;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (!finished) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d words required=%0d", got.size(), nw);
    end
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 1);
    @(negedge clk);
    chk("done_low", done, 0);
    chk("busy_low", busy, 0);
  endtask

  initial begin
    int c0, d0, e0;
    for (int a = 0; a < 2048; a++) mem[a] = 1'($urandom);
    reset = 1'b1; start = 1'b0; num_bits = '0;
    in_valid = 1'b0; in_idx = '0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_en", {bram_wea, bram_web}, 0);
    chk("rst_addr", {bram_addra, bram_addrb}, 0);
    chk("rst_din", {bram_dina, bram_dinb}, 0);
    chk("rst_drop", drop_cnt, 0);
    reset = 1'b0;

    for (int r = 0; r < 4; r++) vecs[r] = '0;
    vecs[0].nb = 70;  vecs[0].nw = 3; vecs[0].rdy = 100; vecs[0].clr = 48; vecs[0].nexp = 3;
    vecs[0].idx[0] = 0;  vecs[0].idx[1] = 33; vecs[0].idx[2] = 69; vecs[0].val = 4'b0111;
    vecs[0].exp[0] = 32'h1; vecs[0].exp[1] = 32'h2; vecs[0].exp[2] = 32'h20;
    vecs[1].nb = 64;  vecs[1].nw = 1; vecs[1].rdy = 100; vecs[1].clr = 32; vecs[1].nexp = 2;
    vecs[1].idx[0] = 5; vecs[1].val = 4'b0001;
    vecs[1].exp[0] = 32'h20; vecs[1].exp[1] = 32'h0;
    vecs[2].nb = 32;  vecs[2].nw = 2; vecs[2].rdy = 100; vecs[2].clr = 16; vecs[2].nexp = 1;
    vecs[2].idx[0] = 40; vecs[2].idx[1] = 3; vecs[2].val = 4'b0011; vecs[2].drop = 1;
    vecs[2].exp[0] = 32'h8;
    vecs[3].nb = 256; vecs[3].nw = 2; vecs[3].rdy = 30; vecs[3].clr = 128; vecs[3].nexp = 8;
    vecs[3].idx[0] = 0; vecs[3].idx[1] = 255; vecs[3].val = 4'b0011;
    vecs[3].exp[0] = 32'h1; vecs[3].exp[7] = 32'h80000000;

    for (int r = 0; r < 4; r++) begin
      if (r == 1) begin
        // Prior job leaves 64 ones in the BRAM so the next job proves its clear.
        wq_idx.delete(); wq_bit.delete();
        for (int k = 0; k < 64; k++) begin wq_idx.push_back(k); wq_bit.push_back(1'b1); end
        exp_q.delete(); exp_q.push_back(32'hFFFFFFFF); exp_q.push_back(32'hFFFFFFFF);
        run_job(64, 100, 0, 1'b0);
        cmp_words("fill");
      end
      wq_idx.delete(); wq_bit.delete(); exp_q.delete();
      for (int k = 0; k < int'(vecs[r].nw); k++) begin
        wq_idx.push_back(int'(vecs[r].idx[k]));
        wq_bit.push_back(vecs[r].val[k]);
      end
      for (int k = 0; k < int'(vecs[r].nexp); k++) exp_q.push_back(vecs[r].exp[k]);
      c0 = clr_cnt; d0 = done_cnt;
      run_job(int'(vecs[r].nb), int'(vecs[r].rdy), 0, 1'b0);
      cmp_words($sformatf("vec%0d", r));
      chk($sformatf("vec%0d_drop", r), drop_cnt, vecs[r].drop);
      chk($sformatf("vec%0d_clear_cycles", r), clr_cnt - c0, vecs[r].clr);
      chk($sformatf("vec%0d_done_count", r), done_cnt - d0, 1);
    end

    // Empty job: straight to DONE, no BRAM traffic.
    e0 = en_cnt; d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; num_bits = '0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_busy", busy, 1);
    chk("zero_done", done, 1);
    @(negedge clk);
    chk("zero_busy_after", busy, 0);
    chk("zero_done_after", done, 0);
    chk("zero_bram_enables", en_cnt - e0, 0);
    chk("zero_done_count", done_cnt - d0, 1);

    // Reset in the middle of a drain, then a fresh job.
    wq_idx.delete(); wq_bit.delete();
    wq_idx.push_back(7); wq_bit.push_back(1'b1);
    d0 = done_cnt;
    run_job(256, 100, 2, 1'b0);
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_drop", drop_cnt, 0);
    chk("abort_no_done", done_cnt - d0, 0);
    wq_idx.delete(); wq_bit.delete();
    wq_idx.push_back(31); wq_bit.push_back(1'b1);
    exp_q.delete(); exp_q.push_back(32'h80000000);
    run_job(32, 100, 0, 1'b0);
    cmp_words("post_abort");

    // Randomised jobs against the reference model.
    for (int j = 0; j < 6; j++) begin
      int nb, nwr;
      nb  = $urandom_range(1, 300);
      nwr = $urandom_range(1, 12);
      wq_idx.delete(); wq_bit.delete();
      for (int k = 0; k < nwr; k++) begin
        wq_idx.push_back($urandom_range(0, nb + 20));
        wq_bit.push_back(1'($urandom));
      end
      model(nb);
      d0 = done_cnt;
      run_job(nb, $urandom_range(20, 100), 0, 1'b1);
      cmp_words($sformatf("rand%0d_nb%0d", j, nb));
      chk($sformatf("rand%0d_drop", j), drop_cnt, exp_drop);
      chk($sformatf("rand%0d_done_count", j), done_cnt - d0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
